// File: rtl/dot_pkg.sv
// dot_pkg: shared constants and types for the dot collector.
//   DOT_X / DOT_Y : fixed dot position table (10-bit pixels). Row 0 holds the
//                   default 16-dot row at (40+32*i, 100); further rows repeat
//                   the X pattern at lower Y so N_DOTS up to 64 is covered.
//   HIT_R_DEF     : default hit radius; HIT_R2 is its square.
//   collector_state_t : scan FSM states.
package dot_pkg;

  localparam int unsigned DOT_TABLE_N = 64;

  localparam logic [9:0] DOT_X [DOT_TABLE_N] = '{
    10'd40, 10'd72, 10'd104, 10'd136, 10'd168, 10'd200, 10'd232, 10'd264,
    10'd296, 10'd328, 10'd360, 10'd392, 10'd424, 10'd456, 10'd488, 10'd520,
    10'd40, 10'd72, 10'd104, 10'd136, 10'd168, 10'd200, 10'd232, 10'd264,
    10'd296, 10'd328, 10'd360, 10'd392, 10'd424, 10'd456, 10'd488, 10'd520,
    10'd40, 10'd72, 10'd104, 10'd136, 10'd168, 10'd200, 10'd232, 10'd264,
    10'd296, 10'd328, 10'd360, 10'd392, 10'd424, 10'd456, 10'd488, 10'd520,
    10'd40, 10'd72, 10'd104, 10'd136, 10'd168, 10'd200, 10'd232, 10'd264,
    10'd296, 10'd328, 10'd360, 10'd392, 10'd424, 10'd456, 10'd488, 10'd520
  };

  localparam logic [9:0] DOT_Y [DOT_TABLE_N] = '{
    10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100,
    10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100,
    10'd164, 10'd164, 10'd164, 10'd164, 10'd164, 10'd164, 10'd164, 10'd164,
    10'd164, 10'd164, 10'd164, 10'd164, 10'd164, 10'd164, 10'd164, 10'd164,
    10'd228, 10'd228, 10'd228, 10'd228, 10'd228, 10'd228, 10'd228, 10'd228,
    10'd228, 10'd228, 10'd228, 10'd228, 10'd228, 10'd228, 10'd228, 10'd228,
    10'd292, 10'd292, 10'd292, 10'd292, 10'd292, 10'd292, 10'd292, 10'd292,
    10'd292, 10'd292, 10'd292, 10'd292, 10'd292, 10'd292, 10'd292, 10'd292
  };

  localparam int unsigned HIT_R_DEF = 8;
  localparam int unsigned HIT_R2    = HIT_R_DEF * HIT_R_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } collector_state_t;

endpackage

// File: rtl/dot_collector_hit_check.sv
// hit_check: combinational distance test between player and one dot.
//   i_px, i_py       : latched player position
//   i_dot_x, i_dot_y : dot position from the table
//   i_r2             : hit radius squared
//   o_hit            : dx^2 + dy^2 <= i_r2
module hit_check (
  input  logic [9:0]  i_px,
  input  logic [9:0]  i_py,
  input  logic [9:0]  i_dot_x,
  input  logic [9:0]  i_dot_y,
  input  logic [21:0] i_r2,
  output logic        o_hit
);

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic        [10:0] w_adx;
  logic        [10:0] w_ady;
  logic        [21:0] w_sum;

  // Magnitudes are at most 1023, so each square fits 20 bits and the sum
  // fits 22 bits without overflow.
  always_comb begin
    w_dx  = $signed({1'b0, i_px}) - $signed({1'b0, i_dot_x});
    w_dy  = $signed({1'b0, i_py}) - $signed({1'b0, i_dot_y});
    w_adx = w_dx[10] ? 11'(-w_dx) : 11'(w_dx);
    w_ady = w_dy[10] ? 11'(-w_dy) : 11'(w_dy);
    w_sum = (22'(w_adx) * 22'(w_adx)) + (22'(w_ady) * 22'(w_ady));
    o_hit = (w_sum <= i_r2);
  end

endmodule

// File: rtl/dot_collector.sv
// dot_collector: once per frame, scans the dot table against the player
// position and issues one-cycle kill pulses for live dots within radius.
//   Clk, Reset        : clock, synchronous active-high reset
//   frame_start       : pulse, starts a scan (ignored while busy)
//   respawn           : restores all dots alive, score kept
//   PosX, PosY        : player position, sampled at scan start
//   kill_valid/_idx   : one-cycle kill pulse and eaten dot index
//   kill_vec          : one-hot kill pulses to the per-dot instances
//   alive             : per-dot alive bitmap
//   score             : saturating count of dots eaten
//   busy, scan_done   : scan in progress / end-of-scan pulse
//   all_eaten         : no dot alive
module dot_collector
  import dot_pkg::*;
#(
  parameter  int unsigned N_DOTS  = 16,
  parameter  int unsigned HIT_R   = HIT_R_DEF,
  parameter  int unsigned SCORE_W = 8,
  localparam int unsigned IDX_W   = (N_DOTS > 1) ? $clog2(N_DOTS) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               respawn,
  input  logic [9:0]         PosX,
  input  logic [9:0]         PosY,
  output logic               kill_valid,
  output logic [IDX_W-1:0]   kill_idx,
  output logic [N_DOTS-1:0]  kill_vec,
  output logic [N_DOTS-1:0]  alive,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               scan_done,
  output logic               all_eaten
);

  localparam logic [21:0]      R2       = 22'(HIT_R * HIT_R);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOTS - 1);

  collector_state_t   r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [9:0]         r_px;
  logic [9:0]         r_py;
  logic [N_DOTS-1:0]  r_alive;
  logic [SCORE_W-1:0] r_score;
  logic               r_kill_valid;
  logic [IDX_W-1:0]   r_kill_idx;
  logic [N_DOTS-1:0]  r_kill_vec;
  logic               r_scan_done;

  logic [5:0]         w_tidx;
  logic               w_in_range;
  logic               w_hit;

  assign w_tidx = 6'(r_idx);

  hit_check u_hit_check (
    .i_px    (r_px),
    .i_py    (r_py),
    .i_dot_x (DOT_X[w_tidx]),
    .i_dot_y (DOT_Y[w_tidx]),
    .i_r2    (R2),
    .o_hit   (w_in_range)
  );

  // Dead dots are skipped so the score can never count a dot twice.
  assign w_hit = (r_state == SCAN) && r_alive[r_idx] && w_in_range;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_alive      <= '1;
      r_score      <= '0;
      r_kill_valid <= 1'b0;
      r_kill_idx   <= '0;
      r_kill_vec   <= '0;
      r_scan_done  <= 1'b0;
    end else begin
      r_kill_valid <= 1'b0;
      r_kill_vec   <= '0;
      r_scan_done  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_px    <= PosX;
            r_py    <= PosY;
            r_idx   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_scan_done <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_hit) begin
        r_kill_valid <= 1'b1;
        r_kill_idx   <= r_idx;
        r_kill_vec   <= N_DOTS'(1) << r_idx;
        if (r_score != '1) begin
          r_score <= r_score + 1'b1;
        end
      end

      // Respawn overrides a same-cycle kill: the pulse and score still
      // happen, but the dot stays alive.
      if (respawn) begin
        r_alive <= '1;
      end else if (w_hit) begin
        r_alive[r_idx] <= 1'b0;
      end
    end
  end

  assign kill_valid = r_kill_valid;
  assign kill_idx   = r_kill_idx;
  assign kill_vec   = r_kill_vec;
  assign alive      = r_alive;
  assign score      = r_score;
  assign scan_done  = r_scan_done;
  assign busy       = (r_state != IDLE);
  assign all_eaten  = (r_alive == '0);

endmodule

// File: tb/tb_dot_collector.sv
module tb_dot_collector;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        respawn;
  logic [9:0]  PosX;
  logic [9:0]  PosY;

  // dut: default radius 8, 8-bit score
  logic        kv0, busy0, done0, ae0;
  logic [3:0]  kidx0;
  logic [15:0] kvec0, alive0;
  logic [7:0]  score0;
  // dut16: radius 16, 4-bit score
  logic        kv1, busy1, done1, ae1;
  logic [3:0]  kidx1;
  logic [15:0] kvec1, alive1;
  logic [3:0]  score1;

  dot_collector #(.N_DOTS(16), .HIT_R(8), .SCORE_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .respawn(respawn),
    .PosX(PosX), .PosY(PosY), .kill_valid(kv0), .kill_idx(kidx0),
    .kill_vec(kvec0), .alive(alive0), .score(score0), .busy(busy0),
    .scan_done(done0), .all_eaten(ae0)
  );

  dot_collector #(.N_DOTS(16), .HIT_R(16), .SCORE_W(4)) dut16 (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .respawn(respawn),
    .PosX(PosX), .PosY(PosY), .kill_valid(kv1), .kill_idx(kidx1),
    .kill_vec(kvec1), .alive(alive1), .score(score1), .busy(busy1),
    .scan_done(done1), .all_eaten(ae1)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned cyc;
    int unsigned idx;
  } ev_t;

  ev_t         q0[$];
  ev_t         q1[$];
  int unsigned d0[$];
  int unsigned d1[$];

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [15:0] m_al0, m_al1;
  int unsigned m_sc0, m_sc1;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Kill and scan_done monitors: each pulse must match the head of its queue.
  always @(negedge Clk) begin
    ev_t e;
    logic exp_now;
    exp_now = (q0.size() > 0) && (q0[0].cyc == cyc);
    if (kv0 || exp_now) begin
      chk("r8_kill_valid", 64'(kv0), 64'(exp_now));
      if (exp_now) begin
        e = q0.pop_front();
        if (kv0) begin
          chk("r8_kill_idx", 64'(kidx0), 64'(e.idx));
          chk("r8_kill_vec", 64'(kvec0), 64'(1) << e.idx);
          chk("r8_alive_bit", 64'(alive0[e.idx]), 64'd0);
        end
      end
    end
    exp_now = (q1.size() > 0) && (q1[0].cyc == cyc);
    if (kv1 || exp_now) begin
      chk("r16_kill_valid", 64'(kv1), 64'(exp_now));
      if (exp_now) begin
        e = q1.pop_front();
        if (kv1) begin
          chk("r16_kill_idx", 64'(kidx1), 64'(e.idx));
          chk("r16_kill_vec", 64'(kvec1), 64'(1) << e.idx);
          chk("r16_alive_bit", 64'(alive1[e.idx]), 64'd0);
        end
      end
    end
    exp_now = (d0.size() > 0) && (d0[0] == cyc);
    if (done0 || exp_now) begin
      chk("r8_scan_done", 64'(done0), 64'(exp_now));
      if (exp_now) void'(d0.pop_front());
    end
    exp_now = (d1.size() > 0) && (d1[0] == cyc);
    if (done1 || exp_now) begin
      chk("r16_scan_done", 64'(done1), 64'(exp_now));
      if (exp_now) void'(d1.pop_front());
    end
  end

  // Reference: default row of dots at (40+32*i, 100).
  task automatic model_scan(input int x, input int y, input int unsigned e);
    for (int i = 0; i < 16; i++) begin
      int dx;
      int dy;
      int d2;
      dx = x - (40 + 32 * i);
      dy = y - 100;
      d2 = dx * dx + dy * dy;
      if (m_al0[i] && d2 <= 64) begin
        q0.push_back('{e + 1 + unsigned'(i), unsigned'(i)});
        m_al0[i] = 1'b0;
        if (m_sc0 < 255) m_sc0++;
      end
      if (m_al1[i] && d2 <= 256) begin
        q1.push_back('{e + 1 + unsigned'(i), unsigned'(i)});
        m_al1[i] = 1'b0;
        if (m_sc1 < 15) m_sc1++;
      end
    end
    d0.push_back(e + 17);
    d1.push_back(e + 17);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_r8_alive"}, 64'(alive0), 64'(m_al0));
    chk({tag, "_r8_score"}, 64'(score0), 64'(m_sc0));
    chk({tag, "_r8_all_eaten"}, 64'(ae0), 64'(m_al0 == 16'h0));
    chk({tag, "_r8_busy"}, 64'(busy0), 64'd0);
    chk({tag, "_r16_alive"}, 64'(alive1), 64'(m_al1));
    chk({tag, "_r16_score"}, 64'(score1), 64'(m_sc1));
    chk({tag, "_r16_all_eaten"}, 64'(ae1), 64'(m_al1 == 16'h0));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_kill_valid"}, 64'({kv0, kv1}), 64'd0);
    chk({tag, "_kill_vec"}, 64'({kvec0, kvec1}), 64'd0);
    chk({tag, "_kill_idx"}, 64'({kidx0, kidx1}), 64'd0);
    chk({tag, "_scan_done"}, 64'({done0, done1}), 64'd0);
    chk({tag, "_busy"}, 64'({busy0, busy1}), 64'd0);
    chk({tag, "_all_eaten"}, 64'({ae0, ae1}), 64'd0);
    chk({tag, "_alive"}, 64'({alive0, alive1}), 64'hFFFF_FFFF);
    chk({tag, "_score"}, 64'({score0, score1}), 64'd0);
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); d0.delete(); d1.delete();
    m_al0 = '1; m_al1 = '1; m_sc0 = 0; m_sc1 = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    check_reset(tag);
  endtask

  // Full scan; with extra set, redundant frame_start pulses land in SCAN and DONE.
  task automatic run_scan(input string tag, input int x, input int y, input bit extra);
    int unsigned e;
    @(negedge Clk);
    e = cyc + 1;
    PosX = 10'(x);
    PosY = 10'(y);
    frame_start = 1'b1;
    model_scan(x, y, e);
    for (int k = 0; k <= 17; k++) begin
      @(negedge Clk);
      frame_start = extra && (k == 5 || k == 16);
    end
    frame_start = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned e;
    Reset = 1'b1; frame_start = 1'b0; respawn = 1'b0; PosX = '0; PosY = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset("por");
    Reset = 1'b0;

    run_scan("s1_eat0", 40, 100, 1'b0);
    run_scan("s2_repeat", 40, 100, 1'b0);
    run_scan("s3_far", 79, 106, 1'b0);
    run_scan("s3_near", 78, 105, 1'b0);

    do_reset("rst_a");
    run_scan("s4_between", 56, 100, 1'b0);

    // Reset four cycles into a scan aimed at dot 8: no pulse may follow.
    @(negedge Clk);
    e = cyc + 1;
    PosX = 10'd296; PosY = 10'd100; frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    while (cyc < e + 4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    check_reset("mid_rst");
    repeat (20) @(negedge Clk);
    check_state("post_rst");

    run_scan("s5_ignore_fs", 296, 100, 1'b1);

    do_reset("rst_b");
    for (int i = 0; i < 16; i++) run_scan("s6_eat", 40 + 32 * i, 100, 1'b0);
    chk("s6_r8_score16", 64'(score0), 64'd16);
    chk("s6_r16_score_sat", 64'(score1), 64'd15);
    chk("s6_all_eaten", 64'({ae0, ae1}), 64'b11);

    @(negedge Clk);
    respawn = 1'b1;
    @(negedge Clk);
    respawn = 1'b0;
    m_al0 = '1; m_al1 = '1;
    check_state("respawn");
    run_scan("s7_after_respawn", 40, 100, 1'b0);

    repeat (3) @(negedge Clk);
    chk("kill_queue_r8_empty", 64'(q0.size()), 64'd0);
    chk("kill_queue_r16_empty", 64'(q1.size()), 64'd0);
    chk("done_queue_empty", 64'(d0.size() + d1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
